// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR widths and the output saturation helper
package fir_pkg;

    localparam int FIR_DOUT_W  = 29;
    localparam int SINK_DOUT_W = 12;

    // True when t does not fit in out_w unsigned bits, i.e. t > 2^out_w - 1.
    function automatic logic sat_over(input logic [63:0] t, input int out_w);
        return (t >> out_w) != 64'd0;
    endfunction

endpackage

// File: rtl/fir_out_sink_fifo.sv
// rtl/fir_out_sink_fifo.sv - synchronous show-ahead FIFO with level, full and empty
module fir_out_sink_fifo #(
    parameter int DW    = 12,
    parameter int DEPTH = 8
)(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_clr,
    input  logic                     i_wr_en,
    input  logic [DW-1:0]            i_wr_data,
    input  logic                     i_rd_en,
    output logic [DW-1:0]            o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

    // A read needs data; a write into a full FIFO only lands when a read frees a slot.
    assign w_rd = i_rd_en && !o_empty && !i_clr;
    assign w_wr = i_wr_en && (!o_full || w_rd) && !i_clr;

    // Head is forced to zero when empty so the output never shows stale storage.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];

    // Storage array; contents are only observable through a non-empty head.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally; level counts independently so full and empty are unambiguous.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_sink.sv
// rtl/fir_out_sink.sv - FIR result decimate/scale/buffer stage; FIR_OUT_SINK_ROUND_EN selects round-half-up scaling
module fir_out_sink
    import fir_pkg::*;
#(
    parameter int DIN_W      = FIR_DOUT_W,
    parameter int DOUT_W     = SINK_DOUT_W,
    parameter int SHIFT      = 11,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
)(
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           valid_in,
    input  logic [DIN_W-1:0]               din,
    input  logic                           clr,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic [DOUT_W-1:0]              dout,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           sat,
    output logic                           ovf
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int SW   = DIN_W + 1;

    logic [PH_W-1:0]   r_ph;
    logic              r_s1_valid;
    logic [DOUT_W-1:0] r_s1_data;
    logic              r_sat;
    logic              r_ovf;

    logic              w_keep;
    logic [SW-1:0]     w_sum;
    logic [SW-1:0]     w_t;
    logic              w_over;
    logic [DOUT_W-1:0] w_scaled;
    logic              w_rd;
    logic              w_full;
    logic              w_empty;

    // Keep the first result of every DECIM-long group; a strobe under clr is discarded.
    assign w_keep = valid_in && (r_ph == '0) && !clr;

    // One extra bit so the rounding add can never wrap.
`ifdef FIR_OUT_SINK_ROUND_EN
    generate
        if (SHIFT > 0) begin : g_round
            assign w_sum = {1'b0, din} + (SW'(1) << (SHIFT - 1));
        end else begin : g_no_round
            assign w_sum = {1'b0, din};
        end
    endgenerate
`else
    assign w_sum = {1'b0, din};
`endif

    assign w_t      = w_sum >> SHIFT;
    assign w_over   = sat_over(64'(w_t), DOUT_W);
    assign w_scaled = w_over ? '1 : w_t[DOUT_W-1:0];

    // Decimation phase advances on every strobe and restarts on clr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ph <= '0;
        end else if (clr) begin
            r_ph <= '0;
        end else if (valid_in) begin
            r_ph <= (r_ph == PH_W'(DECIM - 1)) ? '0 : r_ph + PH_W'(1);
        end
    end

    // Scale stage register; sat pulses alongside the clipped sample's s1_valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_sat      <= 1'b0;
        end else if (clr) begin
            r_s1_valid <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_s1_valid <= w_keep;
            r_sat      <= w_keep && w_over;
            if (w_keep) begin
                r_s1_data <= w_scaled;
            end
        end
    end

    assign w_rd = !w_empty && dout_ready && !clr;

    // Sticky drop flag: a scaled sample arrived at a full FIFO with nothing leaving.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (r_s1_valid && w_full && !w_rd) begin
            r_ovf <= 1'b1;
        end
    end

    fir_out_sink_fifo #(
        .DW    (DOUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .i_clr     (clr),
        .i_wr_en   (r_s1_valid),
        .i_wr_data (r_s1_data),
        .i_rd_en   (w_rd),
        .o_rd_data (dout),
        .o_level   (fifo_level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign dout_valid = !w_empty;
    assign sat        = r_sat;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_fir_out_sink.sv
// tb/tb_fir_out_sink.sv - table-driven and scoreboard bench for fir_out_sink
module tb_fir_out_sink;

    localparam int DEC = 4;

    logic        clk;
    logic        rstn;
    logic        valid_in;
    logic [28:0] din;
    logic        clr;
    logic        dout_valid;
    logic        dout_ready;
    logic [11:0] dout;
    logic [3:0]  fifo_level;
    logic        sat;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    int m_ph   = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic [28:0] din;
        logic [11:0] dout;
        logic        sat;
    } vec_t;
    vec_t vt[10];

    fir_out_sink #(
        .DIN_W      (29),
        .DOUT_W     (12),
        .SHIFT      (11),
        .DECIM      (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .valid_in   (valid_in),
        .din        (din),
        .clr        (clr),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .fifo_level (fifo_level),
        .sat        (sat),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_scale(input logic [28:0] d, output logic s);
        longint unsigned t;
        t = 64'(d);
`ifdef FIR_OUT_SINK_ROUND_EN
        t = t + 1024;
`endif
        t = t / 2048;
        s = (t > 4095);
        return s ? 12'd4095 : t[11:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_e(input logic [28:0] d, input logic [11:0] e);
        valid_in = 1'b1;
        din      = d;
        if (m_ph == 0) exp_q.push_back(e);
        m_ph = (m_ph + 1) % DEC;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic strobe(input logic [28:0] d);
        logic s;
        logic [11:0] e;
        e = ref_scale(d, s);
        strobe_e(d, e);
    endtask

    task automatic filler(input int n);
        for (int i = 0; i < n; i++) strobe(29'($urandom));
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_q.delete();
        m_ph = 0;
    endtask

    task automatic drain(input string name);
        dout_ready = 1'b1;
        for (int i = 0; i < 40 && fifo_level != 0; i++) tick();
        tick();
        dout_ready = 1'b0;
        chk(name, fifo_level, 0);
    endtask

    // Scoreboard: every handshake pops and compares the oldest expected sample.
    always @(negedge clk) begin
        if (rstn === 1'b1 && clr === 1'b0 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra act=%0d exp=none", dout);
            end else begin
                chk("sb_dout", dout, exp_q.pop_front());
                n_out++;
            end
        end
    end

    initial begin
        int n0;
        vt[0] = '{29'd0,         12'd0,    1'b0};
        vt[1] = '{29'd2048,      12'd1,    1'b0};
`ifdef FIR_OUT_SINK_ROUND_EN
        vt[2] = '{29'd3072,      12'd2,    1'b0};
        vt[3] = '{29'd2047,      12'd1,    1'b0};
        vt[5] = '{29'd8387584,   12'd4095, 1'b1};
        vt[9] = '{29'd4095,      12'd2,    1'b0};
`else
        vt[2] = '{29'd3072,      12'd1,    1'b0};
        vt[3] = '{29'd2047,      12'd0,    1'b0};
        vt[5] = '{29'd8387584,   12'd4095, 1'b0};
        vt[9] = '{29'd4095,      12'd1,    1'b0};
`endif
        vt[4] = '{29'd8386560,   12'd4095, 1'b0};
        vt[6] = '{29'd8388608,   12'd4095, 1'b1};
        vt[7] = '{29'd8591310,   12'd4095, 1'b1};
        vt[8] = '{29'd536870911, 12'd4095, 1'b1};

        rstn = 1'b0; valid_in = 1'b0; din = '0; clr = 1'b0; dout_ready = 1'b0;
        repeat (2) tick();
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_sat", sat, 0);
        chk("rst_ovf", ovf, 0);
        rstn = 1'b1;
        tick();

        // Decimation: 2048*k for k=0..7 yields exactly 0 and 4.
        dout_ready = 1'b1;
        n0 = n_out;
        strobe(29'd0);
        chk("dec_lat_early", dout_valid, 0);
        strobe(29'd2048);
        chk("dec_lat_valid", dout_valid, 1);
        for (int k = 2; k < 8; k++) strobe(29'(2048 * k));
        repeat (4) tick();
        dout_ready = 1'b0;
        chk("dec_count", n_out - n0, 2);
        chk("dec_level", fifo_level, 0);

        // Scaling table: rounding, saturation edges and sat pulse width.
        for (int i = 0; i < 10; i++) begin
            strobe_e(vt[i].din, vt[i].dout);
            chk("tbl_sat", sat, vt[i].sat);
            tick();
            chk("tbl_valid", dout_valid, 1);
            chk("tbl_sat_end", sat, 0);
            dout_ready = 1'b1;
            tick();
            dout_ready = 1'b0;
            filler(DEC - 1);
        end
        chk("tbl_level", fifo_level, 0);

        // Back-pressure: nine samples into an eight-deep FIFO.
        for (int v = 1; v <= 8; v++) begin
            strobe(29'(2048 * v));
            filler(DEC - 1);
        end
        repeat (3) tick();
        chk("bp_level8", fifo_level, 8);
        chk("bp_ovf_pre", ovf, 0);
        chk("bp_head", dout, 1);
        strobe(29'(2048 * 9));
        filler(DEC - 1);
        repeat (3) tick();
        chk("bp_level_full", fifo_level, 8);
        chk("bp_ovf", ovf, 1);
        chk("bp_head_hold", dout, 1);
        void'(exp_q.pop_back());
        drain("bp_drain");
        chk("bp_ovf_sticky", ovf, 1);
        chk("bp_empty_valid", dout_valid, 0);

        // Full FIFO with a read in the same cycle as a write.
        clr_pulse();
        chk("clr_ovf", ovf, 0);
        for (int v = 10; v <= 17; v++) begin
            strobe(29'(2048 * v));
            filler(DEC - 1);
        end
        repeat (3) tick();
        chk("fr_level_pre", fifo_level, 8);
        strobe(29'(2048 * 18));
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("fr_level", fifo_level, 8);
        chk("fr_ovf", ovf, 0);
        filler(DEC - 1);
        drain("fr_drain");

        // clr with level 5 and phase 2, coincident strobe discarded.
        for (int v = 20; v <= 23; v++) begin
            strobe(29'(2048 * v));
            filler(DEC - 1);
        end
        strobe(29'(2048 * 24));
        filler(1);
        repeat (3) tick();
        chk("clr_level_pre", fifo_level, 5);
        clr = 1'b1; valid_in = 1'b1; din = 29'(2048 * 7);
        tick();
        clr = 1'b0; valid_in = 1'b0;
        exp_q.delete();
        m_ph = 0;
        chk("clr_level", fifo_level, 0);
        chk("clr_valid", dout_valid, 0);
        chk("clr_ovf2", ovf, 0);
        strobe(29'(2048 * 3));
        tick();
        chk("clr_kept", dout_valid, 1);
        chk("clr_kept_dout", dout, 3);
        filler(DEC - 1);
        drain("clr_drain");

        // Asynchronous reset in the middle of a transfer.
        for (int v = 1; v <= 9; v++) begin
            strobe(29'(2048 * v));
            filler(DEC - 1);
        end
        repeat (3) tick();
        chk("ar_ovf_pre", ovf, 1);
        dout_ready = 1'b1;
        tick();
        #2 rstn = 1'b0;
        #1;
        chk("ar_valid", dout_valid, 0);
        chk("ar_dout", dout, 0);
        chk("ar_level", fifo_level, 0);
        chk("ar_sat", sat, 0);
        chk("ar_ovf", ovf, 0);
        exp_q.delete();
        m_ph = 0;
        dout_ready = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        strobe(29'(2048 * 5));
        filler(DEC - 1);
        drain("ar_after");

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_out_sink.md
# fir_out_sink

Receive-side stage for the parallel FIR output stream. It accepts the `valid`/29-bit result stream, decimates by a fixed factor and scales each kept result to a 12-bit sample by shift, optional rounding and saturation. It buffers the samples in a small FIFO and presents them on a ready/valid handshake to the downstream consumer. It sits directly after the FIR and absorbs downstream back-pressure, because the FIR itself cannot stall.

## Interface
Parameters:
- DIN_W, 29: input result width (unsigned).
- DOUT_W, 12: output sample width (unsigned).
- SHIFT, 11: right-shift applied before saturation, range 0..DIN_W-1. Default matches FIR DC gain ≈ 2^11.
- DECIM, 4: keep one result in DECIM, range 1..16.
- FIFO_DEPTH, 8: power of 2, ≥2.

Ports (reset rstn, asynchronous, active-low; clock clk):
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- valid_in  in  1  one-cycle strobe, din valid.
- din  in  DIN_W  FIR result.
- clr  in  1  synchronous flush.
- dout_valid  out  1  FIFO non-empty.
- dout_ready  in  1  consumer accepts dout this cycle.
- dout  out  DOUT_W  FIFO head sample.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- sat  out  1  one-cycle pulse, the scaled sample was clipped.
- ovf  out  1  sticky, a sample was dropped because the FIFO was full.

## Operation
- **Decimation**
  - Phase counter ph counts 0..DECIM-1, advances on every valid_in and wraps to 0.
  - A sample is kept only when valid_in=1 and ph=0, so the first valid_in after reset or clr is kept.
  - DECIM=1 keeps every sample.
- **Scale stage (s1, one register stage)**
  - Computes t = din >> SHIFT, using DIN_W+1-bit arithmetic with the rounding add (see Configuration).
  - If t > 2^DOUT_W-1, then s1_data = 2^DOUT_W-1 and sat pulses. Otherwise s1_data = t[DOUT_W-1:0].
  - s1_valid is high for one cycle after each kept sample.
- **FIFO write**
  - Each s1_valid cycle writes s1_data.
  - If the FIFO is full and no read occurs in the same cycle, the sample is dropped and ovf sets.
  - If full and a read occurs in the same cycle, the write succeeds and ovf is not set.
- **Read**
  - dout shows the FIFO head (show-ahead). dout_valid = (level≠0).
  - A transfer happens when dout_valid && dout_ready. dout_ready while empty is ignored.
  - dout and dout_valid hold stable while dout_valid && !dout_ready.
- **clr**
  - Highest priority in its cycle.
  - Next cycle: level=0, dout_valid=0, ph=0, s1_valid=0, ovf=0.
  - A valid_in coincident with clr is discarded.
- **Pointers**
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Level is tracked by a separate counter: +1 write only, −1 read only, unchanged when both or neither occur.

## Timing
- Reset values: dout_valid=0, dout=0, fifo_level=0, sat=0, ovf=0, ph=0, s1_valid=0.
- Reset is asynchronous and may assert mid-stream; all state clears immediately.
- Latency: valid_in sampled at edge E → s1 registered at E → FIFO written at E+1 → dout_valid=1 after E+1. This is two cycles into an empty FIFO.
- sat is asserted in the same cycle as s1_valid.
- ovf rises in the cycle after the dropped write's edge.
- Throughput is one sample per cycle on both sides. valid_in may be high on consecutive cycles.

## Configuration
- `FIR_OUT_SINK_ROUND_EN` defined: add 2^(SHIFT-1) to din before shifting (round half up). For SHIFT=0, no add.
- Undefined: plain truncation, and the adder is removed.

## Structure
- Package fir_pkg holds:
  - FIR_DOUT_W=29 and SINK_DOUT_W=12 constants, shared with the FIR.
  - The saturation helper function.
- One sub-module, fir_out_sink_fifo: synchronous show-ahead FIFO with level, full and empty outputs. Decimation, scaling and flags stay in the top module.

## Test plan
1. **Decimation:** DECIM=4, eight consecutive valid_in with din=2048·k (k=0..7) → exactly two outputs, 0 and 4. dout_valid rises 2 cycles after the k=0 strobe.
2. **Rounding:** din=3072, SHIFT=11 → dout=2 with `FIR_OUT_SINK_ROUND_EN`, dout=1 without.
3. **Saturation:** din=8591310 (full-scale FIR output) → dout=4095, sat high exactly one cycle. din=8386560 → dout=4095, sat=0.
4. **Back-pressure:** dout_ready=0, DECIM=1, nine samples 1..9 → level=8, ovf=1, sample 9 lost. Then dout_ready=1 drains 1..8 in order, and level reaches 0.
5. **Full with simultaneous read:** FIFO full, dout_ready=1 in the same cycle as a write → level stays 8, ovf stays 0, and the new sample appears last.
6. **clr and reset mid-stream:**
   - clr with level=5 and ph=2 → next cycle level=0, dout_valid=0, ovf=0, and the next valid_in is kept.
   - rstn pulsed low mid-transfer → all outputs 0 immediately.
